pool_frame_collector: RTL and testbench
=======================================

Name: pool_frame_collector

Overview:
- Sink for the pooling layer's output stream. Captures each valid pooled pixel vector into an on-chip frame buffer in raster order.
- Flags when the full pooled frame is present, then lets the downstream reader drain it sequentially with a read-enable / read-valid handshake.
- Sits between the last pooling layer and the host readout path of the CNN top.

Parameters:
- CHANNELS, 5, channels per pixel vector
- I_WIDTH, 16, bits per channel (signed two's complement)
- OUT_SIZE, 7, pooled frame side: floor((IMAGE_SIZE-FILTER_SIZE)/STRIDE)+1 for 15/2/2
- Derived (localparam): DEPTH = OUT_SIZE*OUT_SIZE; AW = clog2(DEPTH); DW = CHANNELS*I_WIDTH

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- clk_en  input  1  global clock enable; all state frozen when low
- input_data  input  DW  pooled pixel vector, channel 0 in LSBs
- valid  input  1  input_data qualifier from the pooling layer
- rd_en  input  1  reader requests next stored pixel
- rd_data  output  DW  pixel read out
- rd_valid  output  1  rd_data qualifier, single-cycle pulse per read
- rd_row  output  clog2(OUT_SIZE)  row index of rd_data
- rd_col  output  clog2(OUT_SIZE)  column index of rd_data
- frame_done  output  1  high while a complete frame is held (HOLD state)
- overflow  output  1  sticky: a valid pixel arrived while in HOLD

Behaviour:
- Reset (async, rst_n=0):
  - state=FILL; wr_ptr=0; rd_ptr=0.
  - rd_valid=0, frame_done=0, overflow=0, rd_row=0, rd_col=0, rd_data=0.
  - Buffer contents are not reset.
- Advance qualifier: every transition below occurs only on a rising clk edge with clk_en=1. With clk_en=0 all registers hold, and rd_valid holds its value.
- FILL state:
  - valid=1 writes input_data to mem[wr_ptr] and increments wr_ptr.
  - The write at wr_ptr=DEPTH-1 sets wr_ptr=0, state=HOLD and frame_done=1 on the next cycle.
  - rd_en is ignored; rd_valid=0.
- HOLD state:
  - valid=1 does not write and sets overflow=1. overflow is sticky until reset.
  - rd_en=1 registers rd_data=mem[rd_ptr] and rd_valid=1 on the next cycle (latency 1), with rd_row/rd_col = rd_ptr / OUT_SIZE, rd_ptr % OUT_SIZE.
  - rd_ptr then increments. rd_en=0 gives rd_valid=0 next cycle.
  - The read of rd_ptr=DEPTH-1 sets rd_ptr=0, state=FILL and frame_done=0. Its rd_valid pulse is still emitted.
- Simultaneous valid and final read in HOLD: the pixel is dropped and overflow=1. The state changes only after that edge, so the next frame starts with the following valid.
- Row/column counters are maintained incrementally (col wraps at OUT_SIZE-1, row increments); no divider is used.
- Buffer: single write port, single registered read port, inferable as block RAM. Reads never see a same-cycle write, because reads and writes occur in mutually exclusive states.
- Reset mid-frame: partial frame is discarded; wr_ptr=0 at release.

Optional Feature:
- Macro: POOL_COLLECTOR_CHANMAX_EN.
- Defined:
  - Adds output chan_max (DW).
  - Per channel, holds the signed maximum of all pixels written in the current frame.
  - Loaded (not compared) by the write at wr_ptr=0; updated by compare on every subsequent FILL write.
  - Stable through HOLD; reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset release, then 49 valid pixels with value = index in every channel -> frame_done=1 exactly one cycle after the 49th write; overflow=0.
- After fill, rd_en held high 49 cycles -> rd_valid pulses for 49 consecutive cycles; rd_data = 0..48; (rd_row, rd_col) goes (0,0)…(6,6); frame_done drops after the last read; state=FILL.
- Fill with clk_en toggling 1/0 and valid high throughout -> exactly one write per clk_en=1 cycle; frame_done after 49 enabled cycles. Read with rd_en=1 and clk_en low every other cycle -> rd_valid held while clk_en=0, 49 distinct reads total.
- In HOLD, pulse valid with data 0xFFFF… -> overflow=1 and stays 1. A subsequent full readout still returns the original 0..48.
- Assert rst_n=0 after 20 writes, release, write 49 pixels of value 100+i -> readout returns 100..148.
- With POOL_COLLECTOR_CHANMAX_EN: channel 2 values {-5, 3, 0x7FFF, -32768, …} with all others ≤ 10 -> chan_max channel 2 = 0x7FFF. A second frame with all values -1 -> chan_max = 0xFFFF per channel (previous frame's max not carried over).

Source files
------------

// File: rtl/pool_frame_collector.sv
// Pooled-frame collector: fills a DEPTH-entry buffer in raster order, then holds it for a sequential read-out.
// Optional per-channel signed maximum output when POOL_COLLECTOR_CHANMAX_EN is defined.
module pool_frame_collector #(
  parameter  int CHANNELS = 5,
  parameter  int I_WIDTH  = 16,
  parameter  int OUT_SIZE = 7,
  localparam int DEPTH    = OUT_SIZE * OUT_SIZE,
  localparam int AW       = $clog2(DEPTH),
  localparam int DW       = CHANNELS * I_WIDTH,
  localparam int RW       = $clog2(OUT_SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  input  logic [DW-1:0] input_data,
  input  logic          valid,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [RW-1:0] rd_row,
  output logic [RW-1:0] rd_col,
  output logic          frame_done,
`ifdef POOL_COLLECTOR_CHANMAX_EN
  output logic [DW-1:0] chan_max,
`endif
  output logic          overflow
);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [RW-1:0] row_q, row_d, col_q, col_d;
  logic [RW-1:0] rd_row_q, rd_row_d, rd_col_q, rd_col_d;
  logic          rd_valid_q, rd_valid_d;
  logic          overflow_q, overflow_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          wr_fire, rd_fire;

  logic [DW-1:0] mem [DEPTH];

  assign wr_fire = clk_en && (state_q == ST_FILL) && valid;
  assign rd_fire = clk_en && (state_q == ST_HOLD) && rd_en;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    row_d      = row_q;
    col_d      = col_q;
    rd_row_d   = rd_row_q;
    rd_col_d   = rd_col_q;
    rd_valid_d = rd_valid_q;
    overflow_d = overflow_q;
    rd_data_d  = rd_data_q;

    if (clk_en) rd_valid_d = rd_fire;
    if (clk_en && (state_q == ST_HOLD) && valid) overflow_d = 1'b1;

    if (wr_fire) begin
      if (wr_ptr_q == AW'(DEPTH - 1)) begin
        wr_ptr_d = '0;
        state_d  = ST_HOLD;
      end else begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
    end

    // row/col shadow rd_ptr incrementally so no divide is needed for the index outputs
    if (rd_fire) begin
      rd_data_d = mem[rd_ptr_q];
      rd_row_d  = row_q;
      rd_col_d  = col_q;
      if (col_q == RW'(OUT_SIZE - 1)) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + RW'(1);
      end
      if (rd_ptr_q == AW'(DEPTH - 1)) begin
        rd_ptr_d = '0;
        row_d    = '0;
        col_d    = '0;
        state_d  = ST_FILL;
      end else begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      rd_row_q   <= '0;
      rd_col_q   <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      row_q      <= row_d;
      col_q      <= col_d;
      rd_row_q   <= rd_row_d;
      rd_col_q   <= rd_col_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_q] <= input_data;
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign rd_row     = rd_row_q;
  assign rd_col     = rd_col_q;
  assign frame_done = (state_q == ST_HOLD);
  assign overflow   = overflow_q;

`ifdef POOL_COLLECTOR_CHANMAX_EN
  logic [DW-1:0] cmax_q, cmax_d;

  // first write of a frame loads, so the previous frame's maximum never leaks forward
  always_comb begin
    cmax_d = cmax_q;
    if (wr_fire) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if ((wr_ptr_q == '0) ||
            ($signed(input_data[c*I_WIDTH +: I_WIDTH]) > $signed(cmax_q[c*I_WIDTH +: I_WIDTH])))
          cmax_d[c*I_WIDTH +: I_WIDTH] = input_data[c*I_WIDTH +: I_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmax_q <= '0;
    else        cmax_q <= cmax_d;
  end

  assign chan_max = cmax_q;
`endif

endmodule

// File: tb/tb_pool_frame_collector.sv
// Directed bench for pool_frame_collector: fill, read-out, clock enable, overflow, mid-frame reset.
module tb_pool_frame_collector;
  localparam int CH = 5, IW = 16, OS = 7, DEPTH = 49, DW = 80;

  logic          clk = 1'b0;
  logic          rst_n, clk_en, valid, rd_en;
  logic [DW-1:0] input_data, rd_data;
  logic          rd_valid, frame_done, overflow;
  logic [2:0]    rd_row, rd_col;
`ifdef POOL_COLLECTOR_CHANMAX_EN
  logic [DW-1:0] chan_max;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pool_frame_collector #(.CHANNELS(CH), .I_WIDTH(IW), .OUT_SIZE(OS)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .input_data(input_data), .valid(valid),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rd_row(rd_row), .rd_col(rd_col),
    .frame_done(frame_done),
`ifdef POOL_COLLECTOR_CHANMAX_EN
    .chan_max(chan_max),
`endif
    .overflow(overflow)
  );

  function automatic logic [DW-1:0] pix(input int v);
    logic [IW-1:0] s;
    s = v[IW-1:0];
    return {CH{s}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_frame(input int base, input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      valid = 1'b1;
      input_data = pix(base + i);
      if (i == DEPTH - 1) begin
        checks++;
        if (frame_done !== 1'b0) begin
          failures++;
          $display("FAIL %s_done_early got=%b exp=0", tag, frame_done);
        end
      end
      step();
    end
    valid = 1'b0;
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_after_fill got=%b exp=1", tag, frame_done);
    end
  endtask

  task automatic read_frame(input int base, input bit drop_last, input string tag);
    logic [DW+6:0] got, exp;
    rd_en = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      if (drop_last && k == DEPTH - 1) begin
        valid = 1'b1;
        input_data = '1;
      end
      step();
      valid = 1'b0;
      got = {rd_valid, rd_row, rd_col, rd_data};
      exp = {1'b1, 3'(k / OS), 3'(k % OS), pix(base + k)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s_read%0d got=%h exp=%h", tag, k, got, exp);
      end
    end
    rd_en = 1'b0;
    checks++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_after_read got=%b exp=0", tag, frame_done);
    end
    step();
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_rd_valid_idle got=%b exp=0", tag, rd_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_en = 1'b1; valid = 1'b0; rd_en = 1'b0; input_data = '0;
    #12;
    checks++;
    if ({rd_valid, frame_done, overflow, rd_row, rd_col} !== 9'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {rd_valid, frame_done, overflow, rd_row, rd_col});
    end
    checks++;
    if (rd_data !== '0) begin
      failures++;
      $display("FAIL reset_rd_data got=%h exp=0", rd_data);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_done got=%b exp=0", frame_done);
    end
  endtask

  task automatic test_fill_read();
    fill_frame(0, "fill");
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL fill_overflow got=%b exp=0", overflow);
    end
    read_frame(0, 1'b0, "read");
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL fill_rd_en_ignored got=%b exp=0", rd_valid);
    end
  endtask

  task automatic test_clk_en();
    int n, k, cyc;
    n = 0; cyc = 0;
    while (n < DEPTH && cyc < 200) begin
      clk_en = (cyc % 2 == 0);
      valid = 1'b1;
      input_data = clk_en ? pix(500 + n) : pix(16'hDEAD);
      if (clk_en && n == DEPTH - 1) begin
        checks++;
        if (frame_done !== 1'b0) begin
          failures++;
          $display("FAIL ce_done_early got=%b exp=0", frame_done);
        end
      end
      step();
      if (clk_en) n++;
      cyc++;
    end
    valid = 1'b0; clk_en = 1'b1;
    checks++;
    if (frame_done !== 1'b1 || n != DEPTH) begin
      failures++;
      $display("FAIL ce_fill_done got=%b/%0d exp=1/%0d", frame_done, n, DEPTH);
    end
    k = 0; cyc = 0;
    rd_en = 1'b1;
    while (k < DEPTH && cyc < 200) begin
      clk_en = (cyc % 2 == 0);
      step();
      checks++;
      if (clk_en) begin
        if (rd_valid !== 1'b1 || rd_data !== pix(500 + k) || rd_row !== 3'(k / OS) || rd_col !== 3'(k % OS)) begin
          failures++;
          $display("FAIL ce_read%0d got=%b/%h exp=1/%h", k, rd_valid, rd_data, pix(500 + k));
        end
        k++;
      end else if (rd_valid !== 1'b1 || rd_data !== pix(500 + k - 1)) begin
        failures++;
        $display("FAIL ce_hold%0d got=%b/%h exp=1/%h", k, rd_valid, rd_data, pix(500 + k - 1));
      end
      cyc++;
    end
    clk_en = 1'b1; rd_en = 1'b0;
    checks++;
    if (frame_done !== 1'b0 || k != DEPTH) begin
      failures++;
      $display("FAIL ce_read_done got=%b/%0d exp=0/%0d", frame_done, k, DEPTH);
    end
    step();
  endtask

  task automatic test_overflow();
    fill_frame(0, "ovf_fill");
    valid = 1'b1;
    input_data = '1;
    step();
    valid = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set got=%b exp=1", overflow);
    end
    repeat (3) step();
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky got=%b exp=1", overflow);
    end
    read_frame(0, 1'b1, "ovf_read");
    // the pixel presented with the final read must have been dropped
    fill_frame(300, "ovf_refill");
    read_frame(300, 1'b0, "ovf_reread");
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_end got=%b exp=1", overflow);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20; i++) begin
      valid = 1'b1;
      input_data = pix(i);
      step();
    end
    valid = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({overflow, frame_done} !== 2'b00) begin
      failures++;
      $display("FAIL midrst_state got=%b exp=00", {overflow, frame_done});
    end
    rst_n = 1'b1;
    fill_frame(100, "midrst_fill");
    read_frame(100, 1'b0, "midrst_read");
  endtask

`ifdef POOL_COLLECTOR_CHANMAX_EN
  task automatic test_chanmax();
    logic [IW-1:0] c2, oth;
    for (int i = 0; i < DEPTH; i++) begin
      case (i)
        0: c2 = 16'hFFFB;
        1: c2 = 16'h0003;
        2: c2 = 16'h7FFF;
        3: c2 = 16'h8000;
        default: c2 = 16'((i % 5) - 2);
      endcase
      oth = 16'(i % 11);
      valid = 1'b1;
      input_data = {oth, oth, c2, oth, oth};
      step();
    end
    valid = 1'b0;
    checks++;
    if (chan_max !== {16'd10, 16'd10, 16'h7FFF, 16'd10, 16'd10}) begin
      failures++;
      $display("FAIL chanmax_frame1 got=%h exp=%h", chan_max, {16'd10, 16'd10, 16'h7FFF, 16'd10, 16'd10});
    end
    rd_en = 1'b1;
    repeat (DEPTH) step();
    rd_en = 1'b0;
    checks++;
    if (chan_max !== {16'd10, 16'd10, 16'h7FFF, 16'd10, 16'd10}) begin
      failures++;
      $display("FAIL chanmax_hold got=%h", chan_max);
    end
    for (int i = 0; i < DEPTH; i++) begin
      valid = 1'b1;
      input_data = '1;
      step();
    end
    valid = 1'b0;
    checks++;
    if (chan_max !== {CH{16'hFFFF}}) begin
      failures++;
      $display("FAIL chanmax_frame2 got=%h exp=%h", chan_max, {CH{16'hFFFF}});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_read();
    test_clk_en();
    test_overflow();
    test_reset_mid();
`ifdef POOL_COLLECTOR_CHANMAX_EN
    test_chanmax();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
